// File: rtl/pow2_approx_pkg.sv
// rtl/pow2_approx_pkg.sv - Q4.12 constants and helpers shared by the 2^x approximator
//
// Contents:
//   DATA_W, FRAC_W, INT_W : operand/result geometry (signed Q4.12)
//   MANT_W                : width of the implicit-one mantissa {1, frac}
//   Q_ONE, Q_MAX, Q_ZERO  : 1.0, largest representable positive value, 0.0
//   SAT_INT               : smallest integer part whose result no longer fits
//   pow2_class_e          : which branch of the approximation an operand takes
package pow2_approx_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 12;
  localparam int INT_W  = DATA_W - FRAC_W;
  localparam int MANT_W = FRAC_W + 1;

  localparam logic [DATA_W-1:0] Q_ONE  = 16'h1000;
  localparam logic [DATA_W-1:0] Q_MAX  = 16'h7FFF;
  localparam logic [DATA_W-1:0] Q_ZERO = 16'h0000;

  // 2^3 = 8.0 already exceeds the positive Q4.12 range.
  localparam logic signed [INT_W-1:0] SAT_INT = 4'sd3;

  typedef enum logic [1:0] {
    P2_SHIFT_LEFT  = 2'd0,  // 0 <= i <= 2 : mantissa scaled up
    P2_SHIFT_RIGHT = 2'd1,  // i < 0       : mantissa scaled down, truncated
    P2_SATURATE    = 2'd2   // i >= 3      : clamp to Q_MAX
  } pow2_class_e;

  // Classify an operand by its signed integer part.
  function automatic pow2_class_e pow2_classify(input logic signed [INT_W-1:0] int_part);
    pow2_class_e cls;
    if (int_part[INT_W-1]) begin
      cls = P2_SHIFT_RIGHT;
    end else if (int_part >= SAT_INT) begin
      cls = P2_SATURATE;
    end else begin
      cls = P2_SHIFT_LEFT;
    end
    return cls;
  endfunction

endpackage

// File: rtl/pow2_core.sv
// rtl/pow2_core.sv - combinational Mitchell approximation of 2^x for signed Q4.12
//
// Ports:
//   in_x   in  [15:0] operand, signed Q4.12
//   pow2_o out [15:0] approx 2^x = (1 + frac) * 2^i, Q4.12, sign bit always 0
module pow2_core
  import pow2_approx_pkg::*;
(
  input  logic [DATA_W-1:0] in_x,
  output logic [DATA_W-1:0] pow2_o
);

  logic signed [INT_W-1:0] int_part;
  logic [FRAC_W-1:0]       frac;
  logic [MANT_W-1:0]       mant;
  logic [DATA_W-1:0]       mant_ext;
  logic [INT_W-1:0]        rshamt;
  logic [DATA_W-1:0]       left_val;
  logic [DATA_W-1:0]       right_val;
  pow2_class_e             cls;

  assign int_part = in_x[DATA_W-1:FRAC_W];
  assign frac     = in_x[FRAC_W-1:0];
  assign mant     = {1'b1, frac};
  assign mant_ext = {{(DATA_W-MANT_W){1'b0}}, mant};
  assign cls      = pow2_classify(int_part);

  // Magnitude of a negative integer part (1..8); -8 = 4'b1000 negates to
  // itself, which read unsigned is exactly the shift of 8 we want.
  assign rshamt = (~int_part) + 4'd1;

  // Left shift is at most 2, so the 13-bit mantissa never reaches bit 15.
  assign left_val  = mant_ext << int_part[1:0];
  // Right shift drops low bits: truncation toward zero.
  assign right_val = mant_ext >> rshamt;

  always_comb begin
    pow2_o = Q_ZERO;
    unique case (cls)
      P2_SHIFT_LEFT:  pow2_o = left_val;
      P2_SHIFT_RIGHT: pow2_o = right_val;
      P2_SATURATE:    pow2_o = Q_MAX;
      default:        pow2_o = Q_ZERO;
    endcase
  end

endmodule

// File: rtl/pow2_approx.sv
// rtl/pow2_approx.sv - registered 2^x approximator stage with echoed operand and valid strobe
//
// Ports:
//   clk    in         rising-edge clock
//   rst    in         asynchronous active-low reset
//   en     in         block enable; nothing is captured while low
//   ready  in         upstream data-present strobe; capture on en & ready
//   in_x   in  [15:0] operand, signed Q4.12
//   pow2_x out [15:0] approx 2^x of the last captured operand, Q4.12
//   valid  out        one cycle per newly captured result
//   out_x  out [15:0] the operand that produced pow2_x
module pow2_approx
  import pow2_approx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ready,
  input  logic [DATA_W-1:0] in_x,
  output logic [DATA_W-1:0] pow2_x,
  output logic              valid,
  output logic [DATA_W-1:0] out_x
);

  logic              capture;
  logic [DATA_W-1:0] core_pow2;

  logic [DATA_W-1:0] pow2_q, pow2_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic              valid_q, valid_d;

  pow2_core u_core (
    .in_x   (in_x),
    .pow2_o (core_pow2)
  );

  assign capture = en & ready;

  always_comb begin
    pow2_d  = pow2_q;
    x_d     = x_q;
    valid_d = capture;
    if (capture) begin
      pow2_d = core_pow2;
      x_d    = in_x;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pow2_q  <= Q_ZERO;
      x_q     <= Q_ZERO;
      valid_q <= 1'b0;
    end else begin
      pow2_q  <= pow2_d;
      x_q     <= x_d;
      valid_q <= valid_d;
    end
  end

  assign pow2_x = pow2_q;
  assign out_x  = x_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_pow2_approx.sv
// tb/tb_pow2_approx.sv - self-checking bench for pow2_approx
module tb_pow2_approx;

  logic        clk;
  logic        rst;
  logic        en;
  logic        ready;
  logic [15:0] in_x;
  logic [15:0] pow2_x;
  logic        valid;
  logic [15:0] out_x;

  int total;
  int bad;

  logic [15:0] exp_pow2;
  logic [15:0] exp_x;
  logic        exp_valid;

  pow2_approx dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .ready  (ready),
    .in_x   (in_x),
    .pow2_x (pow2_x),
    .valid  (valid),
    .out_x  (out_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 2^(i+f) ~ (1+f) * 2^i with the value scaled by 4096 (Q4.12).
  function automatic logic [15:0] model(input logic [15:0] x);
    int i;
    int m;
    int r;
    i = $signed(x[15:12]);
    m = 4096 + int'(x[11:0]);
    if (i >= 3)      r = 32767;
    else if (i >= 0) r = m * (1 << i);
    else             r = m / (1 << (-i));
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pow2"},  pow2_x, exp_pow2);
    chk({tag, ".x"},     out_x,  exp_x);
    chk({tag, ".valid"}, {15'd0, valid}, {15'd0, exp_valid});
  endtask

  // Drive one cycle of inputs at the falling edge, update the reference
  // state for the next rising edge, then sample 1 time unit after it.
  task automatic step(input logic e, input logic r, input logic [15:0] x, input string tag);
    @(negedge clk);
    en    = e;
    ready = r;
    in_x  = x;
    @(posedge clk);
    exp_valid = e & r;
    if (e & r) begin
      exp_pow2 = model(x);
      exp_x    = x;
    end
    #1;
    chk_all(tag);
  endtask

  // Single-cycle ready pulse followed by an idle cycle.
  task automatic pulse(input logic [15:0] x, input logic [15:0] golden, input string tag);
    step(1'b1, 1'b1, x, tag);
    chk({tag, ".golden"}, pow2_x, golden);
    step(1'b1, 1'b0, x ^ 16'h5A5A, {tag, ".idle"});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    en    = 1'b0;
    ready = 1'b0;
    in_x  = 16'h0000;
    rst   = 1'b0;
    exp_pow2  = 16'h0000;
    exp_x     = 16'h0000;
    exp_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_init");
    @(negedge clk);
    rst = 1'b1;

    // Make outputs nonzero, then reset between edges.
    step(1'b1, 1'b1, 16'h0800, "pre_reset");
    #2;
    rst = 1'b0;
    exp_pow2  = 16'h0000;
    exp_x     = 16'h0000;
    exp_valid = 1'b0;
    #1;
    chk_all("async_reset");
    @(negedge clk);
    rst = 1'b1;

    // Negative sweep.
    pulse(16'hC000, 16'h0100, "neg_m4");
    pulse(16'hC800, 16'h0180, "neg_m3p5");
    pulse(16'hE000, 16'h0400, "neg_m2");
    pulse(16'hFC00, 16'h0E00, "neg_m0p25");

    // Positive sweep.
    pulse(16'h0000, 16'h1000, "pos_0");
    pulse(16'h0800, 16'h1800, "pos_0p5");
    pulse(16'h1000, 16'h2000, "pos_1");
    pulse(16'h2000, 16'h4000, "pos_2");
    pulse(16'h2E00, 16'h7800, "pos_2p875");

    // Saturation / underflow.
    pulse(16'h3000, 16'h7FFF, "sat_3");
    pulse(16'h7FFF, 16'h7FFF, "sat_max");
    pulse(16'h8000, 16'h0010, "neg_m8");
    pulse(16'hD001, 16'h0200, "trunc_m3");
    pulse(16'h8FFF, 16'h001F, "neg_m8_top");

    // Enable low blocks capture.
    step(1'b0, 1'b1, 16'h1234, "en_off_a");
    step(1'b0, 1'b1, 16'h4321, "en_off_b");

    // Back-to-back captures.
    step(1'b1, 1'b1, 16'hF000, "b2b_0");
    step(1'b1, 1'b1, 16'h0400, "b2b_1");
    step(1'b1, 1'b1, 16'h1C00, "b2b_2");
    step(1'b1, 1'b1, 16'hA123, "b2b_3");
    step(1'b0, 1'b0, 16'h0000, "b2b_end");

    // Reset while a capture is pending: no result, no valid.
    @(negedge clk);
    en    = 1'b1;
    ready = 1'b1;
    in_x  = 16'h2000;
    #2;
    rst = 1'b0;
    @(posedge clk);
    exp_pow2  = 16'h0000;
    exp_x     = 16'h0000;
    exp_valid = 1'b0;
    #1;
    chk_all("reset_pending");
    @(negedge clk);
    rst   = 1'b1;
    en    = 1'b0;
    ready = 1'b0;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 200; n++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           16'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
